// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - decodes a multiplexed 7-segment scan into a signed 32-bit value
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 6,
  parameter int STABLE_CYCLES  = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] i_digit_sel,
  input  logic [7:0]            i_segment,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [31:0]           o_value,
  output logic                  o_error,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int            IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  // Internal digit codes: 0..9 numeric, plus blank and minus markers.
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [3:0] CODE_MINUS = 4'd11;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  // Largest magnitudes representable for each sign.
  localparam logic [39:0] POS_LIMIT = 40'h00_7FFF_FFFF;
  localparam logic [39:0] NEG_LIMIT = 40'h00_8000_0000;

  logic [1:0]            state;

  // Stability tracking
  logic [NUM_DIGITS-1:0] prev_sel;
  logic [7:0]            prev_seg;
  logic [7:0]            stab_cnt;
  logic                  inputs_same;

  // Select decoding
  logic [3:0]            sel_ones;
  logic [IW-1:0]         sel_idx;
  logic                  sel_onehot;

  // Segment decoding
  logic [6:0]            seg_norm;
  logic [3:0]            dec_code;
  logic                  dec_legal;

  // Captured frame
  logic [NUM_DIGITS-1:0] mask;
  logic [3:0]            code_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] legal_q;
  logic                  mask_full;
  logic                  capture_fire;
  logic                  handshake;

  // Conversion datapath
  logic [IW-1:0]         conv_idx;
  logic [39:0]           acc;
  logic                  neg_q;
  logic                  err_q;
  logic                  seen_q;
  logic [3:0]            cur_code;
  logic                  cur_legal;
  logic                  cur_num;
  logic                  cur_minus;
  logic [39:0]           acc_next;
  logic                  neg_next;
  logic                  err_next;
  logic                  seen_next;
  logic [31:0]           fin_value;
  logic                  fin_err;
  logic                  fin_ovf;

  // Count asserted select lines and remember which one is set.
  always_comb begin
    sel_ones = 4'd0;
    sel_idx  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_digit_sel[i]) begin
        sel_ones = sel_ones + 4'd1;
        sel_idx  = IW'(i);
      end
    end
  end

  assign sel_onehot  = (sel_ones == 4'd1);
  assign inputs_same = (i_digit_sel == prev_sel) && (i_segment == prev_seg);
  assign seg_norm    = (SEG_ACTIVE_LOW != 0) ? ~i_segment[6:0] : i_segment[6:0];

  // Map the normalised g..a pattern onto a digit code; dp never participates.
  always_comb begin
    dec_code  = 4'd0;
    dec_legal = 1'b1;
    case (seg_norm)
      7'h3F:   dec_code = 4'd0;
      7'h06:   dec_code = 4'd1;
      7'h5B:   dec_code = 4'd2;
      7'h4F:   dec_code = 4'd3;
      7'h66:   dec_code = 4'd4;
      7'h6D:   dec_code = 4'd5;
      7'h7D:   dec_code = 4'd6;
      7'h07:   dec_code = 4'd7;
      7'h7F:   dec_code = 4'd8;
      7'h6F:   dec_code = 4'd9;
      7'h00:   dec_code = CODE_BLANK;
      7'h40:   dec_code = CODE_MINUS;
      default: dec_legal = 1'b0;
    endcase
  end

  assign handshake    = (state == ST_PRESENT) && i_ready;
  assign mask_full    = &mask;
  // Fires only on the step into STABLE_MAX, so a long hold captures once.
  assign capture_fire = (state == ST_COLLECT) && sel_onehot && inputs_same &&
                        (stab_cnt == STABLE_MAX - 8'd1);

  // Stability counter: restart on any input change or a non-one-hot select.
  always_ff @(posedge clk_i) begin
    if (rst || handshake) begin
      prev_sel <= '0;
      prev_seg <= 8'd0;
      stab_cnt <= 8'd0;
    end else begin
      prev_sel <= i_digit_sel;
      prev_seg <= i_segment;
      if (!inputs_same || !sel_onehot) begin
        stab_cnt <= 8'd1;
      end else if (stab_cnt != STABLE_MAX) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
    end
  end

  // Capture stable digits into the frame store while collecting.
  always_ff @(posedge clk_i) begin
    if (rst || handshake) begin
      mask    <= '0;
      legal_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        code_q[i] <= 4'd0;
      end
    end else if (capture_fire) begin
      mask[sel_idx]    <= 1'b1;
      legal_q[sel_idx] <= dec_legal;
      code_q[sel_idx]  <= dec_code;
    end
  end

  assign cur_code  = code_q[conv_idx];
  assign cur_legal = legal_q[conv_idx];
  assign cur_num   = cur_legal && (cur_code <= 4'd9);
  assign cur_minus = cur_legal && (cur_code == CODE_MINUS);

  // One decimal step per cycle plus the running sign/error bookkeeping.
  always_comb begin
    acc_next  = (acc << 3) + (acc << 1) + {36'd0, (cur_num ? cur_code : 4'd0)};
    neg_next  = neg_q | cur_minus;
    // A minus is only legal as the first non-blank symbol of the frame.
    err_next  = err_q | !cur_legal | (cur_minus && (seen_q || neg_q));
    seen_next = seen_q | cur_num;
  end

  // Final result with error taking precedence over saturation.
  always_comb begin
    fin_value = 32'd0;
    fin_err   = 1'b0;
    fin_ovf   = 1'b0;
    if (err_next) begin
      fin_err = 1'b1;
    end else if (neg_next) begin
      if (acc_next > NEG_LIMIT) begin
        fin_value = 32'h8000_0000;
        fin_ovf   = 1'b1;
      end else begin
        fin_value = 32'd0 - acc_next[31:0];
      end
    end else begin
      if (acc_next > POS_LIMIT) begin
        fin_value = 32'h7FFF_FFFF;
        fin_ovf   = 1'b1;
      end else begin
        fin_value = acc_next[31:0];
      end
    end
  end

  // Control FSM: collect a full frame, convert MSD first, hold the result.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state      <= ST_COLLECT;
      conv_idx   <= '0;
      acc        <= 40'd0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      seen_q     <= 1'b0;
      o_valid    <= 1'b0;
      o_value    <= 32'd0;
      o_error    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (mask_full) begin
            state    <= ST_CONVERT;
            conv_idx <= LAST_IDX;
            acc      <= 40'd0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            seen_q   <= 1'b0;
          end
        end
        ST_CONVERT: begin
          acc      <= acc_next;
          neg_q    <= neg_next;
          err_q    <= err_next;
          seen_q   <= seen_next;
          conv_idx <= conv_idx - IDX_ONE;
          if (conv_idx == '0) begin
            state      <= ST_PRESENT;
            o_valid    <= 1'b1;
            o_value    <= fin_value;
            o_error    <= fin_err;
            o_overflow <= fin_ovf;
          end
        end
        ST_PRESENT: begin
          if (i_ready) begin
            state   <= ST_COLLECT;
            o_valid <= 1'b0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign o_busy = (state != ST_COLLECT);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder (6 and 12 digits)
module tb_seg7_scan_decoder;

  typedef struct packed {
    logic [31:0] value;
    logic        err;
    logic        ovf;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cyc = 32'd0;

  logic [5:0]  a_sel;
  logic [7:0]  a_seg;
  logic        a_ready;
  logic        a_valid, a_error, a_overflow, a_busy;
  logic [31:0] a_value;

  logic [11:0] b_sel;
  logic [7:0]  b_seg;
  logic        b_ready;
  logic        b_valid, b_error, b_overflow, b_busy;
  logic [31:0] b_value;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  seg7_scan_decoder dut_a (
    .clk_i(clk), .rst(rst), .i_digit_sel(a_sel), .i_segment(a_seg), .i_ready(a_ready),
    .o_valid(a_valid), .o_value(a_value), .o_error(a_error), .o_overflow(a_overflow),
    .o_busy(a_busy)
  );

  seg7_scan_decoder #(.NUM_DIGITS(12)) dut_b (
    .clk_i(clk), .rst(rst), .i_digit_sel(b_sel), .i_segment(b_seg), .i_ready(b_ready),
    .o_valid(b_valid), .o_value(b_value), .o_error(b_error), .o_overflow(b_overflow),
    .o_busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Active-low raw pattern for a bench code (A=blank, B=minus, F=illegal).
  function automatic logic [7:0] seg_of(input logic [3:0] c);
    logic [6:0] n;
    case (c)
      4'h0: n = 7'h3F;  4'h1: n = 7'h06;  4'h2: n = 7'h5B;  4'h3: n = 7'h4F;
      4'h4: n = 7'h66;  4'h5: n = 7'h6D;  4'h6: n = 7'h7D;  4'h7: n = 7'h07;
      4'h8: n = 7'h7F;  4'h9: n = 7'h6F;  4'hA: n = 7'h00;  4'hB: n = 7'h40;
      default: n = 7'h01;
    endcase
    return {1'b1, ~n};
  endfunction

  task automatic hold_a(input int pos, input logic [3:0] c, input int n);
    a_sel = 6'b1 << pos;
    a_seg = seg_of(c);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_b(input int pos, input logic [3:0] c, input int n);
    b_sel = 12'b1 << pos;
    b_seg = seg_of(c);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan_a(input logic [23:0] codes);
    for (int p = 5; p >= 0; p--) hold_a(p, codes[p*4 +: 4], 4);
    a_sel = '0;
  endtask

  task automatic scan_b(input logic [47:0] codes);
    for (int p = 11; p >= 0; p--) hold_b(p, codes[p*4 +: 4], 4);
    b_sel = '0;
  endtask

  // Called right after the final capture edge of a frame.
  task automatic expect_a(input logic [31:0] v, input logic ee, input logic eo);
    q_a.push_back('{v, ee, eo, cyc + 32'd7});
  endtask

  task automatic expect_b(input logic [31:0] v, input logic ee, input logic eo);
    q_b.push_back('{v, ee, eo, cyc + 32'd13});
  endtask

  task automatic drain_a();
    int n = 0;
    while (q_a.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("a_drain_pending", 32'(q_a.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int n = 0;
    while (q_b.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("b_drain_pending", 32'(q_b.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor for the 6-digit instance: compare on each rising o_valid.
  initial begin : mon_a
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && a_valid && !prev_v) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_valid: got value %h expected no result", a_value);
        end else begin
          e = q_a.pop_front();
          check("a_value", a_value, e.value);
          check("a_error", {31'd0, a_error}, {31'd0, e.err});
          check("a_overflow", {31'd0, a_overflow}, {31'd0, e.ovf});
          check("a_latency", cyc, e.due);
        end
      end
      prev_v = a_valid;
    end
  end

  // Monitor for the 12-digit instance.
  initial begin : mon_b
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && b_valid && !prev_v) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_valid: got value %h expected no result", b_value);
        end else begin
          e = q_b.pop_front();
          check("b_value", b_value, e.value);
          check("b_error", {31'd0, b_error}, {31'd0, e.err});
          check("b_overflow", {31'd0, b_overflow}, {31'd0, e.ovf});
          check("b_latency", cyc, e.due);
        end
      end
      prev_v = b_valid;
    end
  end

  initial begin
    rst = 1'b1;
    a_sel = '0; a_seg = 8'hFF; a_ready = 1'b1;
    b_sel = '0; b_seg = 8'hFF; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_a_valid", {31'd0, a_valid}, 32'd0);
    check("rst_a_value", a_value, 32'd0);
    check("rst_a_error", {31'd0, a_error}, 32'd0);
    check("rst_a_overflow", {31'd0, a_overflow}, 32'd0);
    check("rst_a_busy", {31'd0, a_busy}, 32'd0);
    check("rst_b_valid", {31'd0, b_valid}, 32'd0);
    check("rst_b_busy", {31'd0, b_busy}, 32'd0);

    // Basic frames on the 6-digit instance.
    scan_a(24'hAA1234); expect_a(32'h0000_04D2, 1'b0, 1'b0); drain_a();
    scan_a(24'hAAAB42); expect_a(32'hFFFF_FFD6, 1'b0, 1'b0); drain_a();
    scan_a(24'h1B0000); expect_a(32'h0000_0000, 1'b1, 1'b0); drain_a();
    scan_a(24'h123456); expect_a(32'h0001_E240, 1'b0, 1'b0); drain_a();
    scan_a(24'h1A0A0A); expect_a(32'h0001_86A0, 1'b0, 1'b0); drain_a();
    scan_a(24'hBB0001); expect_a(32'h0000_0000, 1'b1, 1'b0); drain_a();
    scan_a(24'hAAF123); expect_a(32'h0000_0000, 1'b1, 1'b0); drain_a();

    // Short hold on position 2 must not complete the frame.
    hold_a(5, 4'h9, 4); hold_a(4, 4'h8, 4); hold_a(3, 4'h7, 4);
    hold_a(2, 4'h6, 3); hold_a(1, 4'h5, 4); hold_a(0, 4'h4, 4);
    a_sel = '0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("short_hold_valid", {31'd0, a_valid}, 32'd0);
    check("short_hold_busy", {31'd0, a_busy}, 32'd0);
    hold_a(2, 4'h6, 4); a_sel = '0;
    expect_a(32'h000F_1206, 1'b0, 1'b0); drain_a();

    // Back-pressure: result held while another number is scanned.
    a_ready = 1'b0;
    scan_a(24'h000777); expect_a(32'h0000_0309, 1'b0, 1'b0); drain_a();
    scan_a(24'h000555);
    @(negedge clk);
    check("hold_valid", {31'd0, a_valid}, 32'd1);
    check("hold_value", a_value, 32'h0000_0309);
    check("hold_busy", {31'd0, a_busy}, 32'd1);
    @(posedge clk); #1 a_ready = 1'b1;
    @(posedge clk); #1 a_ready = 1'b0;
    @(negedge clk);
    check("release_valid", {31'd0, a_valid}, 32'd0);
    check("release_busy", {31'd0, a_busy}, 32'd0);
    hold_a(5, 4'h0, 4); hold_a(4, 4'h0, 4); hold_a(3, 4'h0, 4);
    a_sel = '0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("empty_mask_valid", {31'd0, a_valid}, 32'd0);
    a_ready = 1'b1;
    scan_a(24'h000555); expect_a(32'h0000_022B, 1'b0, 1'b0); drain_a();

    // Reset during the third conversion cycle.
    scan_a(24'h111111);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_convert_busy", {31'd0, a_busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    check("mid_rst_valid", {31'd0, a_valid}, 32'd0);
    check("mid_rst_value", a_value, 32'd0);
    check("mid_rst_error", {31'd0, a_error}, 32'd0);
    check("mid_rst_overflow", {31'd0, a_overflow}, 32'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("mid_rst_no_result", {31'd0, a_valid}, 32'd0);
    scan_a(24'h000042); expect_a(32'h0000_002A, 1'b0, 1'b0); drain_a();

    // 12-digit range boundaries.
    scan_b(48'h999999999999); expect_b(32'h7FFF_FFFF, 1'b0, 1'b1); drain_b();
    scan_b(48'hAB2147483648); expect_b(32'h8000_0000, 1'b0, 1'b0); drain_b();
    scan_b(48'hAA2147483647); expect_b(32'h7FFF_FFFF, 1'b0, 1'b0); drain_b();
    scan_b(48'hAA2147483648); expect_b(32'h7FFF_FFFF, 1'b0, 1'b1); drain_b();
    scan_b(48'hAB2147483649); expect_b(32'h8000_0000, 1'b0, 1'b1); drain_b();

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
